// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the packed {sign, exp, man} floating-point datapath:
// default field widths, bias calculation, field-extract helpers and the
// rounding-mode encoding.
// Ports: none (package).
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam int EXP_W_DEF = 4;
    localparam int MAN_W_DEF = 7;

    typedef enum logic {
        RND_TRUNC = 1'b0,
        RND_RNE   = 1'b1
    } rnd_mode_e;

    function automatic int calc_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Field extractors work on a zero-extended 32-bit copy of the operand so
    // one set of helpers serves every EXP_W/MAN_W combination.
    function automatic logic get_sign(input logic [31:0] v, input int exp_w, input int man_w);
        return v[exp_w + man_w];
    endfunction

    function automatic logic [31:0] get_exp(input logic [31:0] v, input int exp_w, input int man_w);
        return (v >> man_w) & ((32'd1 << exp_w) - 32'd1);
    endfunction

    function automatic logic [31:0] get_man(input logic [31:0] v, input int man_w);
        return v & ((32'd1 << man_w) - 32'd1);
    endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// -----------------------------------------------------------------------------
// fp_mul_pipe_if
// Operand/result handshake bundle for fp_mul_pipe.
//   in_valid/in_ready : operand pair transfer
//   x, y, rnd_mode    : operands and rounding mode (0 truncate, 1 RNE)
//   out_valid/out_ready : result transfer
//   z, of, uf         : product, overflow-saturated, underflow-flushed
// master = producer/consumer side, slave = the multiplier.
// -----------------------------------------------------------------------------
interface fp_mul_pipe_if
    import fp_pkg::*;
#(
    parameter int W = 1 + EXP_W_DEF + MAN_W_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         rnd_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         of;
    logic         uf;

    modport master (
        output in_valid, x, y, rnd_mode, out_ready,
        input  in_ready, out_valid, z, of, uf
    );

    modport slave (
        input  in_valid, x, y, rnd_mode, out_ready,
        output in_ready, out_valid, z, of, uf
    );
endinterface

// File: rtl/fp_round_pack.sv
// -----------------------------------------------------------------------------
// fp_round_pack
// Combinational final stage: rounds the normalised fraction (truncate or
// round-to-nearest-even), renormalises on mantissa carry-out, classifies the
// result (zero / underflow / overflow / normal) and packs it.
//   sign_i, exp_i (signed), frac_i, guard_i, sticky_i, zero_i, rnd_i -> inputs
//   z_o packed result, of_o saturated, uf_o flushed
// -----------------------------------------------------------------------------
module fp_round_pack
    import fp_pkg::*;
#(
    parameter  int EXP_W = EXP_W_DEF,
    parameter  int MAN_W = MAN_W_DEF,
    localparam int W     = 1 + EXP_W + MAN_W,
    localparam int E     = EXP_W + 2
) (
    input  logic                sign_i,
    input  logic signed [E-1:0] exp_i,
    input  logic [MAN_W-1:0]    frac_i,
    input  logic                guard_i,
    input  logic                sticky_i,
    input  logic                zero_i,
    input  logic                rnd_i,
    output logic [W-1:0]        z_o,
    output logic                of_o,
    output logic                uf_o
);
    localparam logic signed [E-1:0] EMAX = E'((1 << EXP_W) - 1);

    logic                inc;
    logic [MAN_W:0]      sum;
    logic signed [E-1:0] exp_r;

    // Ties go up only when the kept lsb is odd.
    assign inc   = (rnd_i == RND_RNE) & guard_i & (sticky_i | frac_i[0]);
    assign sum   = {1'b0, frac_i} + {{MAN_W{1'b0}}, inc};
    // On carry-out the fraction bits are already all zero; only bump exp.
    assign exp_r = exp_i + $signed({{(E-1){1'b0}}, sum[MAN_W]});

    always_comb begin
        z_o  = '0;
        of_o = 1'b0;
        uf_o = 1'b0;
        if (zero_i) begin
            z_o = {sign_i, {(W-1){1'b0}}};
        end else if (exp_r <= 0) begin
            z_o  = {sign_i, {(W-1){1'b0}}};
            uf_o = 1'b1;
        end else if (exp_r > EMAX) begin
            z_o  = {sign_i, {(W-1){1'b1}}};
            of_o = 1'b1;
        end else begin
            z_o = {sign_i, exp_r[EXP_W-1:0], sum[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// -----------------------------------------------------------------------------
// fp_mul_pipe
// Three-stage pipelined floating-point multiplier with valid/ready flow
// control. All stages advance together when the output slot is free or being
// drained (en = !out_valid | out_ready); bubbles are carried, not collapsed.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears all stage valids and outputs
//   bus   : fp_mul_pipe_if.slave (operands in, product/of/uf out)
// -----------------------------------------------------------------------------
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int BIAS  = calc_bias(EXP_W)
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_mul_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int E  = EXP_W + 2;
    localparam int M  = MAN_W + 1;
    localparam int PW = 2 * M;
    localparam logic signed [E-1:0] BIAS_S = E'(BIAS);

    logic en;

    logic                xs, ys;
    logic [EXP_W-1:0]    xe, ye;
    logic [MAN_W-1:0]    xm, ym;
    logic                sign_p1_d, zero_p1_d;
    logic signed [E-1:0] exp_p1_d;
    logic [PW-1:0]       prod_p1_d;

    logic                vld_p1_q, sign_p1_q, zero_p1_q, rnd_p1_q;
    logic signed [E-1:0] exp_p1_q;
    logic [PW-1:0]       prod_p1_q;

    logic [PW-2:0]       norm;
    logic signed [E-1:0] exp_p2_d;
    logic [MAN_W-1:0]    frac_p2_d;
    logic                guard_p2_d, sticky_p2_d;

    logic                vld_p2_q, sign_p2_q, zero_p2_q, rnd_p2_q, guard_p2_q, sticky_p2_q;
    logic signed [E-1:0] exp_p2_q;
    logic [MAN_W-1:0]    frac_p2_q;

    logic [W-1:0]        z_p3_d, z_p3_q;
    logic                of_p3_d, uf_p3_d, of_p3_q, uf_p3_q, vld_p3_q;

    assign en            = ~vld_p3_q | bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_p3_q;
    assign bus.z         = z_p3_q;
    assign bus.of        = of_p3_q;
    assign bus.uf        = uf_p3_q;

    // ---- S1: sign, raw exponent, significand product, zero flag ----
    assign xs = get_sign(32'(bus.x), EXP_W, MAN_W);
    assign ys = get_sign(32'(bus.y), EXP_W, MAN_W);
    assign xe = EXP_W'(get_exp(32'(bus.x), EXP_W, MAN_W));
    assign ye = EXP_W'(get_exp(32'(bus.y), EXP_W, MAN_W));
    assign xm = MAN_W'(get_man(32'(bus.x), MAN_W));
    assign ym = MAN_W'(get_man(32'(bus.y), MAN_W));

    assign sign_p1_d = xs ^ ys;
    assign exp_p1_d  = $signed({2'b00, xe}) + $signed({2'b00, ye}) - BIAS_S;
    assign prod_p1_d = PW'({1'b1, xm}) * PW'({1'b1, ym});
    assign zero_p1_d = (xe == '0) | (ye == '0);

    // ---- S2: normalise product into [1,2), extract guard and sticky ----
    // Product of two [1,2) significands lies in [1,4); the integer 1 bit is
    // dropped here, so norm holds only fraction bits below it.
    assign norm        = prod_p1_q[PW-1] ? prod_p1_q[PW-2:0] : {prod_p1_q[PW-3:0], 1'b0};
    assign exp_p2_d    = exp_p1_q + $signed({{(E-1){1'b0}}, prod_p1_q[PW-1]});
    assign frac_p2_d   = norm[PW-2 -: MAN_W];
    assign guard_p2_d  = norm[PW-2-MAN_W];
    assign sticky_p2_d = |norm[PW-3-MAN_W:0];

    // ---- S3: round, renormalise, classify, pack ----
    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign_i   (sign_p2_q),
        .exp_i    (exp_p2_q),
        .frac_i   (frac_p2_q),
        .guard_i  (guard_p2_q),
        .sticky_i (sticky_p2_q),
        .zero_i   (zero_p2_q),
        .rnd_i    (rnd_p2_q),
        .z_o      (z_p3_d),
        .of_o     (of_p3_d),
        .uf_o     (uf_p3_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            z_p3_q   <= '0;
            of_p3_q  <= 1'b0;
            uf_p3_q  <= 1'b0;
        end else if (en) begin
            vld_p1_q <= bus.in_valid;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
            if (vld_p2_q) begin
                z_p3_q  <= z_p3_d;
                of_p3_q <= of_p3_d;
                uf_p3_q <= uf_p3_d;
            end
        end
    end

    // Datapath registers carry no reset; their valids qualify them.
    always_ff @(posedge clk) begin
        if (en && bus.in_valid) begin
            sign_p1_q <= sign_p1_d;
            exp_p1_q  <= exp_p1_d;
            prod_p1_q <= prod_p1_d;
            zero_p1_q <= zero_p1_d;
            rnd_p1_q  <= bus.rnd_mode;
        end
        if (en && vld_p1_q) begin
            sign_p2_q   <= sign_p1_q;
            exp_p2_q    <= exp_p2_d;
            frac_p2_q   <= frac_p2_d;
            guard_p2_q  <= guard_p2_d;
            sticky_p2_q <= sticky_p2_d;
            zero_p2_q   <= zero_p1_q;
            rnd_p2_q    <= rnd_p1_q;
        end
    end

endmodule
